// File: rtl/fifo_buffer.sv
// fifo_buffer: circular register-array FIFO with write/read/val/full handshake and show-ahead head.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo_buffer #(
  parameter int FIFO_SIZE = 8,
  parameter int DATA_W    = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        write,
  input  logic                        read,
  input  logic [DATA_W-1:0]           data_in,
  output logic [DATA_W-1:0]           data_out,
  output logic                        val,
  output logic                        full,
  output logic [$clog2(FIFO_SIZE):0]  level
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                        overflow,
  output logic                        underflow
`endif
);

  localparam int PTR_W = $clog2(FIFO_SIZE);
  localparam int LVL_W = PTR_W + 1;

  // Handshake: both requests are sampled on the rising clk edge. A push is taken
  // when write=1 and (full=0 or a pop is taken on the same edge); a pop is taken
  // when read=1 and val=1. Requests that are not taken leave all state untouched.
  // val/full/level come from the registered level only, never from write/read.

  logic [DATA_W-1:0] mem [FIFO_SIZE];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              wr_ok;
  logic              rd_ok;

  // Explicit wrap keeps non-power-of-two depths from indexing past the array.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_SIZE - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign val      = (level != '0);
  assign full     = (level == LVL_W'(FIFO_SIZE));
  assign wr_ok    = write & (~full | read);
  assign rd_ok    = read & val;
  assign data_out = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (rd_ok) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow | (write & full & ~read);
      underflow <= underflow | (read & ~val);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_buffer.sv
// Self-checking bench for fifo_buffer: directed vector table, hand sequences for wrap/full/reset
// corners, and randomized traffic against a queue-based reference model.
module tb_fifo_buffer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;

  logic       w8 = 1'b0, r8 = 1'b0;
  logic [7:0] d8 = '0;
  logic [7:0] dout8;
  logic       val8, full8;
  logic [3:0] level8;

  logic       w5 = 1'b0, r5 = 1'b0;
  logic [7:0] d5 = '0;
  logic [7:0] dout5;
  logic       val5, full5;
  logic [3:0] level5;

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf8, udf8, ovf5, udf5;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  logic       exp_ovf = 1'b0;
  logic       exp_udf = 1'b0;

  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] d;
    logic [3:0] lvl;
    logic       vl;
    logic       fl;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[17];

  fifo_buffer #(.FIFO_SIZE(8), .DATA_W(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .write(w8), .read(r8), .data_in(d8),
    .data_out(dout8), .val(val8), .full(full8), .level(level8)
`ifdef FIFO_ERR_FLAGS_EN
    , .overflow(ovf8), .underflow(udf8)
`endif
  );

  fifo_buffer #(.FIFO_SIZE(5), .DATA_W(8)) dut5 (
    .clk(clk), .reset_n(reset_n), .write(w5), .read(r5), .data_in(d5),
    .data_out(dout5), .val(val5), .full(full5), .level(level5)
`ifdef FIFO_ERR_FLAGS_EN
    , .overflow(ovf5), .underflow(udf5)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: FIFO rules applied to a queue, using pre-edge occupancy.
  task automatic model8(input logic w, input logic r, input logic [7:0] d);
    logic f, v;
    f = (exp_q.size() == 8);
    v = (exp_q.size() != 0);
    exp_ovf = exp_ovf | (w & f & ~r);
    exp_udf = exp_udf | (r & ~v);
    if (r && v) void'(exp_q.pop_front());
    if (w && (!f || r)) exp_q.push_back(d);
  endtask

  // driver tasks
  task automatic step8(input logic w, input logic r, input logic [7:0] d);
    w8 = w; r8 = r; d8 = d;
    model8(w, r, d);
    @(posedge clk);
    #1;
    w8 = 1'b0; r8 = 1'b0;
  endtask

  task automatic step5(input logic w, input logic r, input logic [7:0] d);
    w5 = w; r5 = r; d5 = d;
    @(posedge clk);
    #1;
    w5 = 1'b0; r5 = 1'b0;
  endtask

  task automatic check_model8(input string tag);
    check({tag, "_level"}, 32'(level8), 32'(exp_q.size()));
    check({tag, "_val"}, 32'(val8), 32'(exp_q.size() != 0));
    check({tag, "_full"}, 32'(full8), 32'(exp_q.size() == 8));
    if (exp_q.size() != 0) check({tag, "_dout"}, 32'(dout8), 32'(exp_q[0]));
`ifdef FIFO_ERR_FLAGS_EN
    check({tag, "_ovf"}, 32'(ovf8), 32'(exp_ovf));
    check({tag, "_udf"}, 32'(udf8), 32'(exp_udf));
`endif
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      vecs[i].w = 1'b1; vecs[i].r = 1'b0; vecs[i].d = 8'(8'h10 + i);
      vecs[i].lvl = 4'(i + 1); vecs[i].vl = 1'b1; vecs[i].fl = (i == 7);
      vecs[i].dout = 8'h10;
    end
    for (int i = 0; i < 8; i++) begin
      vecs[8+i].w = 1'b0; vecs[8+i].r = 1'b1; vecs[8+i].d = 8'h00;
      vecs[8+i].lvl = 4'(7 - i); vecs[8+i].vl = (i != 7); vecs[8+i].fl = 1'b0;
      vecs[8+i].dout = 8'(8'h11 + i);
    end
    vecs[16].w = 1'b1; vecs[16].r = 1'b1; vecs[16].d = 8'h55;
    vecs[16].lvl = 4'd1; vecs[16].vl = 1'b1; vecs[16].fl = 1'b0; vecs[16].dout = 8'h55;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_level8", 32'(level8), 0);
    check("rst_val8", 32'(val8), 0);
    check("rst_full8", 32'(full8), 0);
    check("rst_level5", 32'(level5), 0);
    check("rst_val5", 32'(val5), 0);
`ifdef FIFO_ERR_FLAGS_EN
    check("rst_ovf8", 32'(ovf8), 0);
    check("rst_udf8", 32'(udf8), 0);
`endif
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // depth-5 wrap: pointers cross 4 -> 0
    for (int i = 0; i < 3; i++) step5(1'b1, 1'b0, 8'(i + 1));
    for (int i = 0; i < 3; i++) begin
      check("w5_pre_dout", 32'(dout5), 32'(i + 1));
      step5(1'b0, 1'b1, 8'h00);
    end
    check("w5_empty", 32'(val5), 0);
    for (int i = 0; i < 5; i++) begin
      step5(1'b1, 1'b0, 8'(8'hA0 + i));
      check("w5_level", 32'(level5), 32'(i + 1));
    end
    check("w5_full", 32'(full5), 1);
    for (int i = 0; i < 5; i++) begin
      check("w5_dout", 32'(dout5), 32'(8'hA0 + i));
      step5(1'b0, 1'b1, 8'h00);
    end
    check("w5_drained_val", 32'(val5), 0);
    check("w5_drained_full", 32'(full5), 0);
`ifdef FIFO_ERR_FLAGS_EN
    check("w5_ovf", 32'(ovf5), 0);
    check("w5_udf", 32'(udf5), 0);
`endif

    // table: fill 0x10..0x17, drain in order, then write+read at empty
    for (int i = 0; i < 17; i++) begin
      step8(vecs[i].w, vecs[i].r, vecs[i].d);
      check($sformatf("vec%0d_level", i), 32'(level8), 32'(vecs[i].lvl));
      check($sformatf("vec%0d_val", i), 32'(val8), 32'(vecs[i].vl));
      check($sformatf("vec%0d_full", i), 32'(full8), 32'(vecs[i].fl));
      if (vecs[i].vl) check($sformatf("vec%0d_dout", i), 32'(dout8), 32'(vecs[i].dout));
    end

    // full with write+read, then dropped write when full
    for (int i = 0; i < 7; i++) step8(1'b1, 1'b0, 8'(8'h80 + i));
    check("fill_full", 32'(full8), 1);
    step8(1'b1, 1'b1, 8'h99);
    check("wr_rd_full_level", 32'(level8), 8);
    check("wr_rd_full_full", 32'(full8), 1);
    check("wr_rd_full_dout", 32'(dout8), 32'h80);
    step8(1'b1, 1'b0, 8'hEE);
    check("drop_level", 32'(level8), 8);
`ifdef FIFO_ERR_FLAGS_EN
    check("drop_ovf", 32'(ovf8), 1);
`endif
    for (int i = 0; i < 8; i++) begin
      check("drain_dout", 32'(dout8), (i < 7) ? 32'(8'h80 + i) : 32'h99);
      check("drain_no_ee", 32'(dout8 == 8'hEE), 0);
      step8(1'b0, 1'b1, 8'h00);
    end
    check_model8("drained");
    step8(1'b0, 1'b1, 8'h00);
    check("rd_empty_level", 32'(level8), 0);
`ifdef FIFO_ERR_FLAGS_EN
    check("rd_empty_udf", 32'(udf8), 1);
    check("ovf_sticky", 32'(ovf8), 1);
`endif

    // randomized traffic, alternating fill-biased and drain-biased phases
    for (int k = 0; k < 600; k++) begin
      int wp;
      wp = ((k / 100) % 2 == 0) ? 75 : 25;
      step8(1'($urandom_range(0, 99) < wp), 1'($urandom_range(0, 99) < (100 - wp)),
            8'($urandom_range(0, 255)));
      check_model8("rand");
    end

    // asynchronous reset mid-stream at level 4
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step8(1'b0, 1'b1, 8'h00);
    check("pre_rst_empty", 32'(level8), 0);
    for (int i = 0; i < 4; i++) step8(1'b1, 1'b0, 8'(8'hC0 + i));
    check("pre_rst_level", 32'(level8), 4);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_val", 32'(val8), 0);
    check("async_rst_level", 32'(level8), 0);
    check("async_rst_full", 32'(full8), 0);
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step8(1'b1, 1'b0, 8'h3C);
    check("post_rst_dout", 32'(dout8), 32'h3C);
    check("post_rst_level", 32'(level8), 1);
    check_model8("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_buffer.md
Name: fifo_buffer

Overview:
Parameterized first-in-first-out buffer. It is the in-order companion to the team's LIFO stack and uses the same write/read/val/full handshake, so producers and consumers can swap between the two without glue logic. Storage is a circular register array with separate read and write pointers. Wrap-around is explicit, so any depth of 2 or more is supported, not only powers of two.

Parameters:
FIFO_SIZE, 8, number of entries (>= 2; non-power-of-2 allowed)
DATA_W, 8, entry width in bits

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
write  input  1  push request; data_in is captured when accepted
read  input  1  pop request; head entry is dropped when accepted
data_in  input  DATA_W  push data
data_out  output  DATA_W  head (oldest) entry, show-ahead
val  output  1  buffer non-empty (level != 0)
full  output  1  level == FIFO_SIZE
level  output  $clog2(FIFO_SIZE)+1  current occupancy, 0..FIFO_SIZE

Behaviour:
- Reset: reset_n low asynchronously clears wr_ptr, rd_ptr and level to 0. Then val=0, full=0, level=0. Memory contents are not reset.
- Reset mid-operation: all pointers clear immediately. Any data in flight is discarded. The first accepted write after release lands at index 0.
- Pointers: wr_ptr and rd_ptr are $clog2(FIFO_SIZE) bits wide. Increment rule: if ptr == FIFO_SIZE-1 it goes to 0, otherwise ptr+1. Neither pointer may index at or beyond FIFO_SIZE.
- Accept rules, evaluated on the same edge:
  - wr_ok = write & (!full | read)
  - rd_ok = read & val
- Write accepted: mem[wr_ptr] <= data_in, wr_ptr advances.
- Read accepted: rd_ptr advances.
- Level update:
  - wr_ok & !rd_ok: +1
  - rd_ok & !wr_ok: -1
  - both: unchanged
  - neither: unchanged
- Empty with write & read together: the write is accepted and the read is ignored (val=0). There is no bypass. Level goes 0->1 and data_out shows the new word on the next cycle.
- Full with write & read together: both are accepted. The head is popped, the new word goes into the freed slot, and full stays 1.
- Write when full with no read: dropped. No state change and memory is not corrupted.
- Read when empty: ignored. No state change.
- data_out = mem[rd_ptr], combinational from the registered state. A push to an empty FIFO has 1-cycle latency (visible after the edge). data_out is don't-care while val=0.
- val, full and level are derived from registered level only. No combinational path from write/read to the flags.
- Ordering: words leave in exactly the order they were accepted, across any number of wraps.

Optional Feature:
Macro FIFO_ERR_FLAGS_EN.
- Defined: adds two outputs, overflow and underflow, each 1 bit and registered, cleared by reset_n.
  - overflow is set sticky on any edge where write & full & !read.
  - underflow is set sticky on any edge where read & !val & !write. It is also set when read & write & !val.
  - Both stay set until reset.
- Not defined: the ports do not exist, and dropped or ignored requests are silent. Core behaviour is identical in both builds.

Test Plan:
- Reset then fill with FIFO_SIZE=8 writes of 0x10..0x17 -> level steps 1..8, full=1 after the 8th edge, data_out=0x10 throughout.
- From full, 8 reads -> data_out sequence 0x10,0x11,...,0x17, val=0 after the last read, level=0, no pointer beyond index 7.
- Wrap at FIFO_SIZE=5: write 3, read 3, write 5 words 0xA0..0xA4 -> full=1 and reads return 0xA0..0xA4 in order, with pointers wrapping 4->0.
- Simultaneous write+read: at level 0 with data_in=0x55 -> level=1 and data_out=0x55. At full with data_in=0x99 -> level stays 8, head advances, 0x99 comes out last.
- Write 0xEE when full with no read -> level stays 8, and the next 8 reads do not return 0xEE. With FIFO_ERR_FLAGS_EN: overflow=1 and stays 1. Read when empty -> underflow=1.
- Assert reset_n low mid-stream at level 4 -> val=0 and level=0 immediately (asynchronous). After release, write 0x3C -> data_out=0x3C.
